pmp_cfg_loader: RTL and testbench



---
 rtl/cep_define.sv | 39 +++
 rtl/pmp_cfg_pack.sv | 21 ++
 rtl/pmp_cfg_loader.sv | 211 +++++++++++++++++++++
 tb/tb_pmp_cfg_loader.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cep_define.sv
// Shared PMP definitions: cfg byte layout, CSR numbers and the CSR loader FSM states.
package cep_define;

    typedef enum logic [1:0] {
        PmpOff   = 2'd0,
        PmpTor   = 2'd1,
        PmpNa4   = 2'd2,
        PmpNapot = 2'd3
    } pmp_a_e;

    typedef struct packed {
        logic       l;
        logic [1:0] rsvd;
        pmp_a_e     a;
        logic       x;
        logic       w;
        logic       r;
    } pmpcfg_t;

    localparam logic [11:0] CSR_PMPADDR0 = 12'h3B0;
    localparam logic [11:0] CSR_PMPCFG0  = 12'h3A0;

    typedef enum logic [2:0] {
        StIdle,
        StAddrWr,
        StAddrRd,
        StCfgWr,
        StCfgRd,
        StFinish
    } loader_state_e;

    function automatic pmpcfg_t pmpcfg_clean(input pmpcfg_t c);
        pmpcfg_t r;
        r      = c;
        r.rsvd = '0;
        return r;
    endfunction

endpackage

// File: rtl/pmp_cfg_pack.sv
// Packs four buffered cfg bytes into one pmpcfg word; bytes past the last region read as zero.
module pmp_cfg_pack
    import cep_define::*;
#(
    parameter int unsigned NUM_REGIONS = 4
) (
    input  logic [1:0]  word_idx,
    input  logic [31:0] raw_bytes,
    output logic [31:0] cfg_word
);

    always_comb begin
        cfg_word = '0;
        for (int k = 0; k < 4; k++) begin
            if ({1'b0, word_idx, 2'(k)} < 5'(NUM_REGIONS)) begin
                cfg_word[8*k +: 8] = pmpcfg_clean(raw_bytes[8*k +: 8]);
            end
        end
    end

endmodule

// File: rtl/pmp_cfg_loader.sv
// Walks the region table and issues pmpaddrN then packed pmpcfgN CSR writes into pmp.
// Read-back verification is built when PMP_LOADER_VERIFY_EN is defined.
module pmp_cfg_loader
    import cep_define::*;
#(
    parameter int unsigned NUM_REGIONS = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [11:0] err_csr,
    output logic [3:0]  tbl_idx,
    input  logic [31:0] tbl_addr,
    input  pmpcfg_t     tbl_cfg,
    output logic        wr_en,
    output logic [31:0] rw_addr,
    output logic [31:0] wdata,
    input  logic [31:0] rdata
);

    localparam int unsigned NUM_WORDS = (NUM_REGIONS + 3) / 4;
    localparam logic [4:0]  LAST_IDX  = 5'(NUM_REGIONS);
    localparam logic [2:0]  LAST_WORD = 3'(NUM_WORDS);

    loader_state_e state_q, state_d;
    logic [4:0]    idx_q, idx_d;
    logic [2:0]    word_q, word_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          wr_en_q, wr_en_d;
    logic [31:0]   rw_addr_q, rw_addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          cfg_we;
    logic          issue_addr, issue_cfg, adv_entry, adv_word, finish;
    logic [31:0]   cfg_word;
    pmpcfg_t       cfg_buf [16];

    // idx_q always points at the entry whose table data is fetched for the next write,
    // so the registered write outputs can be loaded straight from tbl_addr/tbl_cfg.
    assign tbl_idx = idx_q[3:0];

    always_ff @(posedge clock) begin
        if (cfg_we) begin
            cfg_buf[idx_q[3:0]] <= pmpcfg_clean(tbl_cfg);
        end
    end

    pmp_cfg_pack #(
        .NUM_REGIONS(NUM_REGIONS)
    ) u_pack (
        .word_idx (word_q[1:0]),
        .raw_bytes({cfg_buf[{word_q[1:0], 2'd3}], cfg_buf[{word_q[1:0], 2'd2}],
                    cfg_buf[{word_q[1:0], 2'd1}], cfg_buf[{word_q[1:0], 2'd0}]}),
        .cfg_word (cfg_word)
    );

`ifdef PMP_LOADER_VERIFY_EN
    logic        err_q, err_d;
    logic [11:0] err_csr_q, err_csr_d;
    logic        mismatch;
`else
    logic unused_rdata;
    assign unused_rdata = ^rdata;
`endif

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        word_d     = word_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        wr_en_d    = 1'b0;
        rw_addr_d  = rw_addr_q;
        wdata_d    = wdata_q;
        cfg_we     = 1'b0;
        issue_addr = 1'b0;
        issue_cfg  = 1'b0;
        adv_entry  = 1'b0;
        adv_word   = 1'b0;
        finish     = 1'b0;
`ifdef PMP_LOADER_VERIFY_EN
        err_d      = err_q;
        err_csr_d  = err_csr_q;
        mismatch   = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    busy_d     = 1'b1;
                    word_d     = '0;
                    issue_addr = 1'b1;
`ifdef PMP_LOADER_VERIFY_EN
                    err_d      = 1'b0;
                    err_csr_d  = '0;
`endif
                end
            end
`ifdef PMP_LOADER_VERIFY_EN
            StAddrWr: state_d = StAddrRd;
            StCfgWr:  state_d = StCfgRd;
            StAddrRd: begin
                if (rdata != wdata_q) mismatch = 1'b1;
                else                  adv_entry = 1'b1;
            end
            StCfgRd: begin
                if (rdata != wdata_q) mismatch = 1'b1;
                else                  adv_word = 1'b1;
            end
`else
            StAddrWr: adv_entry = 1'b1;
            StCfgWr:  adv_word  = 1'b1;
`endif
            StFinish: begin
                state_d = StIdle;
                idx_d   = '0;
            end
            default: state_d = StIdle;
        endcase

        if (adv_entry) begin
            if (idx_q == LAST_IDX) issue_cfg  = 1'b1;
            else                   issue_addr = 1'b1;
        end
        if (adv_word) begin
            if (word_q == LAST_WORD) finish    = 1'b1;
            else                     issue_cfg = 1'b1;
        end

        if (issue_addr) begin
            state_d   = StAddrWr;
            wr_en_d   = 1'b1;
            rw_addr_d = {20'd0, CSR_PMPADDR0 + {8'd0, idx_q[3:0]}};
            wdata_d   = tbl_addr;
            cfg_we    = 1'b1;
            idx_d     = idx_q + 5'd1;
        end
        if (issue_cfg) begin
            state_d   = StCfgWr;
            wr_en_d   = 1'b1;
            rw_addr_d = {20'd0, CSR_PMPCFG0 + {10'd0, word_q[1:0]}};
            wdata_d   = cfg_word;
            word_d    = word_q + 3'd1;
        end

`ifdef PMP_LOADER_VERIFY_EN
        if (mismatch) begin
            err_d     = 1'b1;
            err_csr_d = rw_addr_q[11:0];
            finish    = 1'b1;
        end
`endif
        if (finish) begin
            state_d = StFinish;
            busy_d  = 1'b0;
`ifdef PMP_LOADER_VERIFY_EN
            done_d  = !err_d;
`else
            done_d  = 1'b1;
`endif
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            word_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            rw_addr_q <= '0;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            word_q    <= word_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            wr_en_q   <= wr_en_d;
            rw_addr_q <= rw_addr_d;
            wdata_q   <= wdata_d;
        end
    end

`ifdef PMP_LOADER_VERIFY_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            err_q     <= 1'b0;
            err_csr_q <= '0;
        end else begin
            err_q     <= err_d;
            err_csr_q <= err_csr_d;
        end
    end
    assign err     = err_q;
    assign err_csr = err_csr_q;
`else
    assign err     = 1'b0;
    assign err_csr = '0;
`endif

    assign busy    = busy_q;
    assign done    = done_q;
    assign wr_en   = wr_en_q;
    assign rw_addr = rw_addr_q;
    assign wdata   = wdata_q;

endmodule

// File: tb/tb_pmp_cfg_loader.sv
// Bench for pmp_cfg_loader: two instances (4 and 6 regions) against a pmp CSR model
// and an operation-list reference built from the table, locks and shadow CSR state.
module tb_pmp_cfg_loader;

`ifdef PMP_LOADER_VERIFY_EN
    localparam bit VERIFY = 1'b1;
`else
    localparam bit VERIFY = 1'b0;
`endif

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset;
    logic        start   [2];
    logic        busy    [2];
    logic        done    [2];
    logic        err     [2];
    logic [11:0] err_csr [2];
    logic [3:0]  tbl_idx [2];
    logic [31:0] tbl_addr[2];
    logic [7:0]  tbl_cfg [2];
    logic        wr_en   [2];
    logic [31:0] rw_addr [2];
    logic [31:0] wdata   [2];
    logic [31:0] rdata   [2];

    logic [31:0] tab_addr [2][16];
    logic [7:0]  tab_cfg  [2][16];
    bit          lock     [2][16];
    logic [31:0] ref_paddr[2][16];
    logic [7:0]  ref_pcfg [2][16];

    logic        op_wr  [$];
    logic [31:0] op_addr[$];
    logic [31:0] op_data[$];
    logic        exp_err;
    logic [11:0] exp_csr;
    logic [31:0] cap_cfg0, cap_cfg1;

    int checks = 0;
    int errors = 0;

    for (genvar g = 0; g < 2; g++) begin : gen_dut
        localparam int unsigned NR = (g == 0) ? 4 : 6;
        logic [31:0] pmp_addr [16] = '{default: '0};
        logic [7:0]  pmp_cfg  [16] = '{default: '0};
        logic [11:0] csr;

        pmp_cfg_loader #(
            .NUM_REGIONS(NR)
        ) dut (
            .clock   (clock),
            .reset   (reset),
            .start   (start[g]),
            .busy    (busy[g]),
            .done    (done[g]),
            .err     (err[g]),
            .err_csr (err_csr[g]),
            .tbl_idx (tbl_idx[g]),
            .tbl_addr(tbl_addr[g]),
            .tbl_cfg (tbl_cfg[g]),
            .wr_en   (wr_en[g]),
            .rw_addr (rw_addr[g]),
            .wdata   (wdata[g]),
            .rdata   (rdata[g])
        );

        assign tbl_addr[g] = tab_addr[g][tbl_idx[g]];
        assign tbl_cfg[g]  = tab_cfg[g][tbl_idx[g]];
        assign csr         = rw_addr[g][11:0];
        assign rdata[g]    = (csr[11:4] == 8'h3B) ? pmp_addr[csr[3:0]] :
                             (csr[11:2] == 10'h0E8) ?
                             {pmp_cfg[{csr[1:0], 2'd3}], pmp_cfg[{csr[1:0], 2'd2}],
                              pmp_cfg[{csr[1:0], 2'd1}], pmp_cfg[{csr[1:0], 2'd0}]} : 32'h0;

        // Locked entries silently ignore writes, like the real pmp block.
        always @(posedge clock) begin
            if (wr_en[g]) begin
                if (csr[11:4] == 8'h3B) begin
                    if (!lock[g][csr[3:0]]) pmp_addr[csr[3:0]] <= wdata[g];
                end else if (csr[11:2] == 10'h0E8) begin
                    for (int k = 0; k < 4; k++) begin
                        if (!lock[g][{csr[1:0], 2'(k)}])
                            pmp_cfg[{csr[1:0], 2'(k)}] <= wdata[g][8*k +: 8];
                    end
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_op(input logic w, input logic [31:0] a, input logic [31:0] d);
        op_wr.push_back(w);
        op_addr.push_back(a);
        op_data.push_back(d);
    endtask

    // Expected per-cycle CSR traffic and final error status for one run.
    task automatic build_ops(input int inst, input int nr);
        logic [31:0] sh_a [16];
        logic [7:0]  sh_c [16];
        logic [31:0] word;
        logic        mism;
        op_wr.delete();
        op_addr.delete();
        op_data.delete();
        exp_err = 1'b0;
        exp_csr = '0;
        for (int i = 0; i < 16; i++) begin
            sh_a[i] = ref_paddr[inst][i];
            sh_c[i] = ref_pcfg[inst][i];
        end
        for (int i = 0; i < nr; i++) begin
            push_op(1'b1, 32'h3B0 + 32'(i), tab_addr[inst][i]);
            if (!lock[inst][i]) sh_a[i] = tab_addr[inst][i];
            if (VERIFY) begin
                push_op(1'b0, 32'h3B0 + 32'(i), 32'h0);
                if (sh_a[i] != tab_addr[inst][i]) begin
                    exp_err = 1'b1;
                    exp_csr = 12'h3B0 + 12'(i);
                    return;
                end
            end
        end
        for (int w = 0; w < (nr + 3) / 4; w++) begin
            word = '0;
            mism = 1'b0;
            for (int k = 0; k < 4; k++) begin
                if (4 * w + k < nr) word[8*k +: 8] = tab_cfg[inst][4*w+k] & 8'h9F;
            end
            push_op(1'b1, 32'h3A0 + 32'(w), word);
            for (int k = 0; k < 4; k++) begin
                if (!lock[inst][4*w+k]) sh_c[4*w+k] = word[8*k +: 8];
                if (sh_c[4*w+k] != word[8*k +: 8]) mism = 1'b1;
            end
            if (VERIFY) begin
                push_op(1'b0, 32'h3A0 + 32'(w), 32'h0);
                if (mism) begin
                    exp_err = 1'b1;
                    exp_csr = 12'h3A0 + 12'(w);
                    return;
                end
            end
        end
    endtask

    task automatic apply_writes(input int inst, input int n);
        int          cnt;
        logic [31:0] a;
        cnt = 0;
        for (int c = 0; c < op_wr.size(); c++) begin
            if (op_wr[c]) begin
                if (cnt == n) break;
                cnt++;
                a = op_addr[c];
                if (a[11:4] == 8'h3B) begin
                    if (!lock[inst][a[3:0]]) ref_paddr[inst][a[3:0]] = op_data[c];
                end else begin
                    for (int k = 0; k < 4; k++) begin
                        if (!lock[inst][{a[1:0], 2'(k)}])
                            ref_pcfg[inst][{a[1:0], 2'(k)}] = op_data[c][8*k +: 8];
                    end
                end
            end
        end
    endtask

    task automatic run_seq(input int inst, input int nr, input bit busy_pulse, input int reset_at);
        int nwr;
        nwr = 0;
        build_ops(inst, nr);
        @(negedge clock);
        start[inst] = 1'b1;
        @(posedge clock);
        #1 start[inst] = 1'b0;
        for (int c = 0; c < op_wr.size(); c++) begin
            @(negedge clock);
            start[inst] = busy_pulse && (c == 0);
            chk("busy_active", 32'(busy[inst]), 32'd1);
            chk("wr_en", 32'(wr_en[inst]), 32'(op_wr[c]));
            chk("rw_addr", rw_addr[inst], op_addr[c]);
            if (op_wr[c]) begin
                chk("wdata", wdata[inst], op_data[c]);
                nwr++;
                if (op_addr[c] == 32'h3A0) cap_cfg0 = wdata[inst];
                if (op_addr[c] == 32'h3A1) cap_cfg1 = wdata[inst];
                if (reset_at != 0 && nwr == reset_at) begin
                    start[inst] = 1'b0;
                    reset = 1'b1;
                    @(negedge clock);
                    reset = 1'b0;
                    chk("reset_wr_en", 32'(wr_en[inst]), 32'd0);
                    chk("reset_busy", 32'(busy[inst]), 32'd0);
                    apply_writes(inst, nwr);
                    return;
                end
            end
        end
        start[inst] = 1'b0;
        @(negedge clock);
        chk("finish_busy", 32'(busy[inst]), 32'd0);
        chk("finish_wr_en", 32'(wr_en[inst]), 32'd0);
        chk("done", 32'(done[inst]), 32'(!exp_err));
        chk("err", 32'(err[inst]), 32'(exp_err));
        chk("err_csr", 32'(err_csr[inst]), 32'(exp_csr));
        @(negedge clock);
        chk("done_pulse", 32'(done[inst]), 32'd0);
        chk("err_sticky", 32'(err[inst]), 32'(exp_err));
        apply_writes(inst, nwr);
    endtask

    task automatic randomize_table(input int inst);
        for (int i = 0; i < 16; i++) begin
            tab_addr[inst][i] = $urandom;
            tab_cfg[inst][i]  = 8'($urandom_range(0, 255));
        end
    endtask

    initial begin
        for (int s = 0; s < 2; s++) begin
            start[s] = 1'b0;
            for (int i = 0; i < 16; i++) begin
                lock[s][i]      = 1'b0;
                ref_paddr[s][i] = '0;
                ref_pcfg[s][i]  = '0;
            end
            randomize_table(s);
        end
        cap_cfg0 = '0;
        cap_cfg1 = '0;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        for (int s = 0; s < 2; s++) begin
            chk("rst_busy", 32'(busy[s]), 32'd0);
            chk("rst_done", 32'(done[s]), 32'd0);
            chk("rst_err", 32'(err[s]), 32'd0);
            chk("rst_err_csr", 32'(err_csr[s]), 32'd0);
            chk("rst_tbl_idx", 32'(tbl_idx[s]), 32'd0);
            chk("rst_wr_en", 32'(wr_en[s]), 32'd0);
            chk("rst_rw_addr", rw_addr[s], 32'd0);
            chk("rst_wdata", wdata[s], 32'd0);
        end
        reset = 1'b0;

        // Four-region directed table.
        for (int i = 0; i < 4; i++) tab_addr[0][i] = 32'h1000_0000 + 32'(i);
        tab_cfg[0][0] = 8'h0C;
        tab_cfg[0][1] = 8'h06;
        tab_cfg[0][2] = 8'h15;
        tab_cfg[0][3] = 8'h1A;
        run_seq(0, 4, 1'b0, 0);
        chk("four_cfg0", cap_cfg0, 32'h1A15_060C);

        // Reserved-bit clearing.
        tab_cfg[0][0] = 8'hFF;
        run_seq(0, 4, 1'b0, 0);
        chk("rsvd_byte0", 32'(cap_cfg0[7:0]), 32'h9F);

        for (int r = 0; r < 3; r++) begin
            randomize_table(0);
            run_seq(0, 4, 1'b0, 0);
            randomize_table(1);
            run_seq(1, 6, 1'b0, 0);
        end

        // Word padding past the last region.
        randomize_table(1);
        for (int i = 6; i < 16; i++) tab_cfg[1][i] = 8'hFF;
        run_seq(1, 6, 1'b0, 0);
        chk("pad_cfg1_hi", 32'(cap_cfg1[31:16]), 32'h0);

        // Locked entry 1 ignores a changed address.
        randomize_table(0);
        tab_addr[0][1] = ref_paddr[0][1] ^ 32'h5A5A_0001;
        lock[0][1] = 1'b1;
        run_seq(0, 4, 1'b0, 0);
`ifdef PMP_LOADER_VERIFY_EN
        chk("lock_err_csr", 32'(err_csr[0]), 32'h3B1);
`endif
        lock[0][1] = 1'b0;

        // Start while busy is ignored, reset during the third write, then a full rerun.
        randomize_table(0);
        run_seq(0, 4, 1'b1, 3);
        run_seq(0, 4, 1'b0, 0);
        randomize_table(1);
        run_seq(1, 6, 1'b1, 3);
        run_seq(1, 6, 1'b0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
